// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: datapath widths, reset PC, NOP encoding and PC stride.
// Included first so every pipeline stage sees the same constants.
package risc_toy_pkg;

   localparam int XLEN    = 32;
   localparam int WADDR_W = 30;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_INC           = 32'd4;

   function automatic logic [XLEN-1:0] wordToByte(input logic [WADDR_W-1:0] wordAddr);
      return {wordAddr, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction that returns from memory while IF/ID is stalled.
// Clear wins over load, load wins over drain.
module fetch_skid
   import risc_toy_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            drain_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o
);

   logic            valid_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction-fetch stage: owns the PC, issues instruction-memory requests and fills IF/ID.
// Absorbs the one-cycle memory latency, parks a returning instruction in the skid during stalls.
module risc_toy_fetch
   import risc_toy_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               CLK,
   input  logic               RST,
   output logic               IREQ,
   output logic [WADDR_W-1:0] IADDR,
   input  logic [XLEN-1:0]    INSTR,
   input  logic               STALL,
   input  logic               REDIRECT,
   input  logic [XLEN-1:0]    REDIRECT_PC,
   output logic               IF_ID_VALID,
   output logic [XLEN-1:0]    IF_ID_INSTR,
   output logic [XLEN-1:0]    IF_ID_PC
);

   logic [XLEN-1:0]    pc_q, pc_d;
   logic               inflightValid_q;
   logic [XLEN-1:0]    inflightPc_q;
   logic               ifIdValid_q, ifIdValid_d;
   logic [XLEN-1:0]    ifIdInstr_q, ifIdInstr_d;
   logic [XLEN-1:0]    ifIdPc_q, ifIdPc_d;

   logic               ireq;
   logic [WADDR_W-1:0] iaddr;
   logic               skidValid;
   logic [XLEN-1:0]    skidInstr;
   logic [XLEN-1:0]    skidPc;
   logic               skidLoad, skidDrain, skidClear;
   logic               unusedRedirectBits;

   assign unusedRedirectBits = ^REDIRECT_PC[1:0];

   // Under a stall we may still issue once into an empty pipe; that instruction lands in the skid.
   always_comb begin
      iaddr = REDIRECT ? REDIRECT_PC[XLEN-1:2] : pc_q[XLEN-1:2];
      ireq  = 1'b0;
      if (RST)
         ireq = 1'b0;
      else if (REDIRECT || !STALL)
         ireq = 1'b1;
      else
         ireq = !skidValid && !inflightValid_q;
      pc_d = ireq ? (wordToByte(iaddr) + PC_INC) : pc_q;
   end

   assign skidClear = REDIRECT;
   assign skidLoad  = !REDIRECT && STALL && inflightValid_q;
   assign skidDrain = !REDIRECT && !STALL && skidValid;

   always_comb begin
      ifIdValid_d = ifIdValid_q;
      ifIdInstr_d = ifIdInstr_q;
      ifIdPc_d    = ifIdPc_q;
      if (REDIRECT) begin
         ifIdValid_d = 1'b0;
      end else if (!STALL) begin
         if (skidValid) begin
            ifIdValid_d = 1'b1;
            ifIdInstr_d = skidInstr;
            ifIdPc_d    = skidPc;
         end else if (inflightValid_q) begin
            ifIdValid_d = 1'b1;
            ifIdInstr_d = INSTR;
            ifIdPc_d    = inflightPc_q;
         end else begin
            ifIdValid_d = 1'b0;
         end
      end
   end

   fetch_skid uSkid (
      .clk_i   (CLK),
      .rst_i   (RST),
      .load_i  (skidLoad),
      .drain_i (skidDrain),
      .clear_i (skidClear),
      .instr_i (INSTR),
      .pc_i    (inflightPc_q),
      .valid_o (skidValid),
      .instr_o (skidInstr),
      .pc_o    (skidPc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q            <= RESET_PC;
         inflightValid_q <= 1'b0;
         inflightPc_q    <= '0;
         ifIdValid_q     <= 1'b0;
         ifIdInstr_q     <= NOP_INSTR;
         ifIdPc_q        <= '0;
      end else begin
         pc_q            <= pc_d;
         inflightValid_q <= ireq;
         inflightPc_q    <= wordToByte(iaddr);
         ifIdValid_q     <= ifIdValid_d;
         ifIdInstr_q     <= ifIdInstr_d;
         ifIdPc_q        <= ifIdPc_d;
      end
   end

   assign IREQ        = ireq;
   assign IADDR       = iaddr;
   assign IF_ID_VALID = ifIdValid_q;
   assign IF_ID_INSTR = ifIdInstr_q;
   assign IF_ID_PC    = ifIdPc_q;

endmodule

// File: doc/risc_toy_fetch.md
# risc_toy_fetch

Instruction-fetch (IF) stage of the RISC_TOY pipeline: owns the program counter, drives the instruction-memory request port, and fills the IF/ID pipeline register consumed by the decoder. It absorbs the one-cycle synchronous instruction-memory latency, holds its output under decode stalls without losing in-flight instructions, and restarts from a new PC on redirect from EX.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IREQ  out  1  instruction-memory request this cycle.
- IADDR  out  30  word address (byte address [31:2]).
- INSTR  in  32  instruction data; valid the cycle after the IREQ that requested it.
- STALL  in  1  IF/ID must hold (hazard unit).
- REDIRECT  in  1  taken branch/jump from EX; flush and restart.
- REDIRECT_PC  in  32  target byte address; bits [1:0] ignored.
- IF_ID_VALID  out  1  IF/ID holds a real instruction.
- IF_ID_INSTR  out  32  fetched instruction.
- IF_ID_PC  out  32  byte address of IF_ID_INSTR, bits [1:0] = 0.

## Operation
- State: pc (next fetch address), inflight_valid/inflight_pc (request issued last cycle), skid_valid/skid_instr/skid_pc (one-entry buffer), IF/ID output registers.
- IADDR = REDIRECT ? REDIRECT_PC[31:2] : pc[31:2].
- IREQ = 0 while RST; else 1 if REDIRECT; else 1 if !STALL; else 1 only if !skid_valid && !inflight_valid.
- pc update on issue: REDIRECT -> {REDIRECT_PC[31:2],2'b00}+4; else pc+4. No issue -> pc holds. Wrap-around at 2^32 is modulo.
- inflight_valid <= IREQ; inflight_pc <= {IADDR,2'b00}.
- REDIRECT (priority over everything): any returning INSTR is discarded; skid_valid <= 0; IF_ID_VALID <= 0 even if STALL.
- No REDIRECT, !STALL: IF/ID <= skid entry if skid_valid (skid cleared); else returning INSTR/inflight_pc if inflight_valid; else IF_ID_VALID <= 0 (bubble).
- No REDIRECT, STALL: IF/ID holds; a returning INSTR is written to the skid.
- Invariant: skid_valid and inflight_valid are never both 1; the skid never overflows.
- No instruction dropped or duplicated across any STALL pattern.

## Timing
- Reset values: IREQ 0, IF_ID_VALID 0, IF_ID_INSTR 0, IF_ID_PC 0; pc = RESET_PC; inflight_valid = skid_valid = 0.
- First IREQ is the first cycle after RST deasserts, with IADDR = RESET_PC[31:2].
- Fetch latency: IREQ in cycle n -> INSTR in n+1 -> IF_ID outputs valid from cycle n+2.
- Redirect at cycle n: IADDR = REDIRECT_PC[31:2] in n (combinational); target in IF/ID from n+2; IF_ID_VALID = 0 in n+1.
- Steady state, no stalls: one instruction per cycle, sequential PCs.
- Stall release: next instruction appears the cycle after STALL falls (from the skid), with no bubble.
- RST mid-operation: all state cleared immediately; an INSTR returning after reset release without a matching request is ignored.

## Structure
- Shared package risc_toy_pkg: XLEN=32, word-address width 30, RESET_PC default, NOP encoding (32'h0), PC increment constant 4.
- One sub-module: fetch_skid, a one-entry valid/instr/pc holding register with load/drain/clear controls.
- PC logic, request control and IF/ID registers stay in risc_toy_fetch.

## Test plan
- Reset release with RESET_PC=0x100, memory returning INSTR = address -> IADDR 0x40,0x41,0x42...; IF_ID_PC 0x100,0x104,... from the 2nd cycle after the first IREQ; VALID stays 1.
- STALL high for 3 cycles mid-stream -> IF/ID holds 0x108; exactly one instruction (0x10C) sits in the skid; IREQ low after the first stall cycle; after release, 0x10C appears next cycle, then 0x110, with no gaps or duplicates.
- REDIRECT to 0x200 at cycle n -> IADDR 0x80 in n, IF_ID_VALID 0 in n+1, IF_ID_PC 0x200 in n+2; the in-flight instruction is never output.
- REDIRECT while STALL=1 and skid full -> skid cleared, VALID 0 next cycle, IREQ 1 with IADDR = target.
- REDIRECT_PC = 0x203 -> IADDR 0x80, IF_ID_PC 0x200.
- RST asserted for 1 cycle mid-stall -> all outputs return to reset values immediately; fetch restarts at RESET_PC.
